// File: rtl/queen_conflict_checker_if.sv
// Handshake and verdict bundle between the row-index decoder and the
// queen conflict checker.
interface queen_conflict_checker_if #(
    parameter int ROW_W = 3
);
    logic             start;
    logic             row_valid;
    logic [ROW_W-1:0] row_in;
    logic             row_ready;
    logic             busy;
    logic             done;
    logic             safe;
    logic [ROW_W-1:0] conflict_col_a;
    logic [ROW_W-1:0] conflict_col_b;

    modport master (
        output start, row_valid, row_in,
        input  row_ready, busy, done, safe, conflict_col_a, conflict_col_b
    );

    modport slave (
        input  start, row_valid, row_in,
        output row_ready, busy, done, safe, conflict_col_a, conflict_col_b
    );
endinterface

// File: rtl/queen_conflict_checker.sv
// Queen conflict checker: loads one row index per column, then walks all
// column pairs (i<j) one per cycle looking for row or diagonal attacks and
// reports the first attacking pair.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for start; verdict registers hold previous result
// S_LOAD  | accepting rows for columns 0..N-1 over valid/ready
// S_CHECK | evaluating pair (i,j) against the stored placement
// S_DONE  | one-cycle done pulse, verdict valid
module queen_conflict_checker #(
    parameter int N     = 8,
    parameter int ROW_W = 3
) (
    input logic                     clk,
    input logic                     rst_n,
    queen_conflict_checker_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ROW_W-1:0] LAST   = ROW_W'(N - 1);
    localparam logic [ROW_W-1:0] PENULT = ROW_W'(N - 2);

    state_t           state_q, state_d;
    logic [ROW_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] i_q, i_d;
    logic [ROW_W-1:0] j_q, j_d;
    logic [ROW_W-1:0] r_q [N];
    logic [ROW_W-1:0] r_d [N];
    logic             safe_q, safe_d;
    logic [ROW_W-1:0] col_a_q, col_a_d;
    logic [ROW_W-1:0] col_b_q, col_b_d;

    logic             row_ready_c;
    logic             busy_c;
    logic             done_c;

    logic [ROW_W-1:0]        row_i;
    logic [ROW_W-1:0]        row_j;
    logic signed [ROW_W:0]   row_diff;
    logic signed [ROW_W:0]   row_diff_abs;
    logic [ROW_W:0]          col_dist;
    logic                    attack;

    // Attack test for the current pair; one extra bit keeps the row
    // difference signed so |r[i]-r[j]| never wraps.
    assign row_i        = r_q[i_q];
    assign row_j        = r_q[j_q];
    assign row_diff     = $signed({1'b0, row_i}) - $signed({1'b0, row_j});
    assign row_diff_abs = (row_diff < 0) ? -row_diff : row_diff;
    assign col_dist     = {1'b0, j_q - i_q};
    assign attack       = (row_i == row_j) || ($unsigned(row_diff_abs) == col_dist);

    // State register and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            safe_q  <= 1'b0;
            col_a_q <= '0;
            col_b_q <= '0;
            for (int k = 0; k < N; k++) begin
                r_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            i_q     <= i_d;
            j_q     <= j_d;
            safe_q  <= safe_d;
            col_a_q <= col_a_d;
            col_b_q <= col_b_d;
            r_q     <= r_d;
        end
    end

    // Next-state, counter and verdict logic plus handshake outputs.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        i_d         = i_q;
        j_d         = j_q;
        r_d         = r_q;
        safe_d      = safe_q;
        col_a_d     = col_a_q;
        col_b_d     = col_b_q;
        row_ready_c = 1'b0;
        busy_c      = 1'b0;
        done_c      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_LOAD;
                    col_d   = '0;
                    safe_d  = 1'b0;
                    col_a_d = '0;
                    col_b_d = '0;
                end
            end

            S_LOAD: begin
                row_ready_c = 1'b1;
                busy_c      = 1'b1;
                if (bus.row_valid) begin
                    r_d[col_q] = bus.row_in;
                    col_d      = col_q + 1'b1;
                    if (col_q == LAST) begin
                        state_d = S_CHECK;
                        i_d     = '0;
                        j_d     = ROW_W'(1);
                    end
                end
            end

            S_CHECK: begin
                busy_c = 1'b1;
                if (attack) begin
                    state_d = S_DONE;
                    safe_d  = 1'b0;
                    col_a_d = i_q;
                    col_b_d = j_q;
                end else if ((i_q == PENULT) && (j_q == LAST)) begin
                    state_d = S_DONE;
                    safe_d  = 1'b1;
                end else if (j_q == LAST) begin
                    i_d = i_q + 1'b1;
                    j_d = i_q + ROW_W'(2);
                end else begin
                    j_d = j_q + 1'b1;
                end
            end

            S_DONE: begin
                done_c  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.row_ready      = row_ready_c;
    assign bus.busy           = busy_c;
    assign bus.done           = done_c;
    assign bus.safe           = safe_q;
    assign bus.conflict_col_a = col_a_q;
    assign bus.conflict_col_b = col_b_q;

endmodule

// File: tb/tb_queen_conflict_checker.sv
// Self-checking bench for queen_conflict_checker: table of boards with
// expected verdicts, a scoreboard of expected results popped on each done,
// and hand sequences for start-while-busy and asynchronous reset.
module tb_queen_conflict_checker;

    localparam int ROW_W = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    queen_conflict_checker_if #(.ROW_W(ROW_W)) bus ();

    queen_conflict_checker #(.N(8), .ROW_W(ROW_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0] rows [8];
        bit         gaps;
        bit         safe;
        logic [2:0] a;
        logic [2:0] b;
        int         cyc;
    } vec_t;

    typedef struct {
        bit         safe;
        logic [2:0] a;
        logic [2:0] b;
        int         cyc;
    } res_t;

    res_t exp_q[$];
    res_t obs_q[$];
    vec_t vecs[5];

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int chk_cyc = 0;

    // Observe verdicts on each done pulse and count CHECK cycles per board.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk_cyc <= 0;
        end else if (bus.done) begin
            res_t o;
            o.safe = bus.safe;
            o.a    = bus.conflict_col_a;
            o.b    = bus.conflict_col_b;
            o.cyc  = chk_cyc;
            obs_q.push_back(o);
            done_cnt <= done_cnt + 1;
            chk_cyc  <= 0;
        end else if (bus.busy && !bus.row_ready) begin
            chk_cyc <= chk_cyc + 1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic feed(input logic [2:0] rows [8], input bit gaps,
                        input int stop_after, input bit start_mid);
        int k;
        int cyc;
        bit acc;
        k = 0;
        cyc = 0;
        while (k < stop_after && cyc < 64) begin
            if (gaps && cyc[0]) begin
                bus.row_valid = 1'b0;
                check("ready_in_gap", int'(bus.row_ready), 1);
            end else begin
                bus.row_valid = 1'b1;
                bus.row_in    = rows[k];
            end
            bus.start = start_mid && (k == 3);
            acc = bus.row_valid && bus.row_ready;
            tick();
            if (acc) k++;
            cyc++;
        end
        bus.row_valid = 1'b0;
        bus.start     = 1'b0;
        check("rows_accepted", k, stop_after);
    endtask

    task automatic run_board(input vec_t v, input bit start_mid, input bit start_in_check);
        res_t e;
        res_t o;
        int   d0;
        d0 = done_cnt;
        e.safe = v.safe;
        e.a    = v.a;
        e.b    = v.b;
        e.cyc  = v.cyc;
        exp_q.push_back(e);
        pulse_start();
        check("ready_in_load", int'(bus.row_ready), 1);
        feed(v.rows, v.gaps, 8, start_mid);
        check("ready_low_after_load", int'(bus.row_ready), 0);
        if (start_in_check) begin
            tick();
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            check("busy_after_start_in_check", int'(bus.busy), 1);
        end
        for (int t = 0; t < 80 && obs_q.size() == 0; t++) tick();
        check("done_seen", obs_q.size(), 1);
        if (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            check("safe", int'(o.safe), int'(e.safe));
            check("col_a", int'(o.a), int'(e.a));
            check("col_b", int'(o.b), int'(e.b));
            check("check_cycles", o.cyc, e.cyc);
            repeat (3) tick();
            check("safe_held", int'(bus.safe), int'(e.safe));
            check("col_a_held", int'(bus.conflict_col_a), int'(e.a));
            check("col_b_held", int'(bus.conflict_col_b), int'(e.b));
            check("done_pulses", done_cnt - d0, 1);
            check("done_low_after", int'(bus.done), 0);
            check("busy_low_after", int'(bus.busy), 0);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.row_valid = 1'b0;
        bus.row_in    = '0;

        vecs[0].rows = '{3'd0, 3'd4, 3'd7, 3'd5, 3'd2, 3'd6, 3'd1, 3'd3};
        vecs[0].gaps = 1'b0; vecs[0].safe = 1'b1; vecs[0].a = 3'd0; vecs[0].b = 3'd0; vecs[0].cyc = 28;
        vecs[1].rows = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
        vecs[1].gaps = 1'b0; vecs[1].safe = 1'b0; vecs[1].a = 3'd0; vecs[1].b = 3'd1; vecs[1].cyc = 1;
        vecs[2].rows = '{3'd0, 3'd2, 3'd4, 3'd6, 3'd1, 3'd3, 3'd5, 3'd7};
        vecs[2].gaps = 1'b0; vecs[2].safe = 1'b0; vecs[2].a = 3'd0; vecs[2].b = 3'd7; vecs[2].cyc = 7;
        vecs[3].rows = '{3'd0, 3'd4, 3'd7, 3'd5, 3'd2, 3'd6, 3'd1, 3'd3};
        vecs[3].gaps = 1'b1; vecs[3].safe = 1'b1; vecs[3].a = 3'd0; vecs[3].b = 3'd0; vecs[3].cyc = 28;
        vecs[4].rows = '{3'd0, 3'd4, 3'd7, 3'd5, 3'd2, 3'd6, 3'd1, 3'd1};
        vecs[4].gaps = 1'b0; vecs[4].safe = 1'b0; vecs[4].a = 3'd3; vecs[4].b = 3'd7; vecs[4].cyc = 22;

        repeat (3) @(posedge clk);
        #1;
        check("rst_row_ready", int'(bus.row_ready), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_safe", int'(bus.safe), 0);
        check("rst_col_a", int'(bus.conflict_col_a), 0);
        check("rst_col_b", int'(bus.conflict_col_b), 0);
        rst_n = 1'b1;
        tick();

        bus.row_valid = 1'b1;
        bus.row_in    = 3'd5;
        repeat (2) tick();
        check("idle_ignores_valid_ready", int'(bus.row_ready), 0);
        check("idle_ignores_valid_busy", int'(bus.busy), 0);
        bus.row_valid = 1'b0;

        for (int v = 0; v < 5; v++) begin
            run_board(vecs[v], 1'b0, 1'b0);
        end

        // start during LOAD and during CHECK must not restart the board
        run_board(vecs[0], 1'b1, 1'b1);

        // asynchronous reset after four rows abandons the board
        begin
            int d0;
            d0 = done_cnt;
            pulse_start();
            feed(vecs[0].rows, 1'b0, 4, 1'b0);
            check("load_busy_before_rst", int'(bus.busy), 1);
            #2;
            rst_n = 1'b0;
            #1;
            check("async_rst_row_ready", int'(bus.row_ready), 0);
            check("async_rst_busy", int'(bus.busy), 0);
            check("async_rst_done", int'(bus.done), 0);
            check("async_rst_safe", int'(bus.safe), 0);
            check("async_rst_col_a", int'(bus.conflict_col_a), 0);
            check("async_rst_col_b", int'(bus.conflict_col_b), 0);
            tick();
            rst_n = 1'b1;
            repeat (40) tick();
            check("no_done_after_rst", done_cnt - d0, 0);
            check("idle_after_rst", int'(bus.busy), 0);
            obs_q.delete();
        end
        run_board(vecs[0], 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
